// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state type, default memory geometry and index-width helper shared by mem_arbiter
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: one-hot grant among valid requesters; MEM_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin
module mem_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int LW = idx_w(N)
) (
    input  logic [N-1:0]  req_valid_i,
    input  logic [LW-1:0] last_grant_i,
    output logic [N-1:0]  grant_o
);

    logic [LW-1:0] idx;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_grant_i;

    always_comb begin
        grant_o = '0;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = LW'(i);
            if (req_valid_i[idx]) grant_o = N'(1) << idx;
        end
    end
`else
    // Scan from lowest to highest priority so the requester nearest after last_grant overwrites the others
    always_comb begin
        grant_o = '0;
        idx     = '0;
        for (int i = N; i >= 1; i--) begin
            idx = LW'((int'(last_grant_i) + i) % N);
            if (req_valid_i[idx]) grant_o = N'(1) << idx;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory among NUM_REQ requesters; MEM_ARB_FIXED_PRIO_EN (in mem_rr_pick) selects fixed priority
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_write_data,
    output logic                      mem_write,
    input  logic [DATA_W-1:0]         mem_read_data
);

    localparam int LW = idx_w(NUM_REQ);

    state_e              state_q, state_d;
    logic [LW-1:0]       owner_q, owner_d;
    logic [LW-1:0]       last_q, last_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]  grant;
    logic [LW-1:0]       win_idx;
    logic                accept;
    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    mem_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_valid_i  (req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant)
    );

    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[LW'(i)]) win_idx = LW'(i);
        end
    end

    // mem_we_d defaults low so mem_write is high only for the ISSUE cycle
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        mem_we_d = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_ISSUE;
                    owner_d  = win_idx;
                    last_d   = win_idx;
                    mem_we_d = req_we[win_idx];
                    addr_d   = addr_arr[win_idx];
                    wdata_d  = wdata_arr[win_idx];
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            last_q   <= LW'(NUM_REQ - 1);
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_write      = mem_we_q;
    assign rsp_valid      = (state_q == ST_RESP && !rst) ? NUM_REQ'(1) << owner_q : '0;
    assign rsp_rdata      = mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a registered-read 1024x32 memory
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, mem_write_data, mem_read_data;
    logic [AW-1:0]   mem_address;
    logic            mem_write;
    logic [DW-1:0]   mem [1024];
    int              vectors = 0;
    int              errors = 0;

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
        mem_read_data <= mem[mem_address];
    end

    task automatic set_req(input int r, input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r] = v;
        req_we[r] = we;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    // Called just after a negedge in IDLE; returns just after the negedge of the next IDLE cycle
    task automatic txn(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output logic [N-1:0] rdy, output logic mwe, output logic [AW-1:0] maddr,
                       output logic [DW-1:0] mwd, output logic [N-1:0] rv, output logic [DW-1:0] rd,
                       output logic mwe_rsp);
        set_req(r, 1'b1, we, a, d);
        #1 rdy = req_ready;
        @(negedge clk);
        set_req(r, 1'b0, 1'b0, '0, '0);
        #1 mwe = mem_write; maddr = mem_address; mwd = mem_write_data;
        @(negedge clk);
        #1 rv = rsp_valid; rd = rsp_rdata; mwe_rsp = mem_write;
        @(negedge clk);
    endtask

    task automatic test_reset();
        req_valid = '1;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        vectors++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        vectors++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
        vectors++; if (mem_address !== 10'h000) begin errors++; $display("FAIL reset_mem_address: got %h expected 000", mem_address); end
        vectors++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_mem_write_data: got %h expected 0", mem_write_data); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write();
        logic [N-1:0] rdy, rv; logic mwe, mwe_rsp; logic [AW-1:0] maddr; logic [DW-1:0] mwd, rd;
        txn(0, 1'b1, 10'h005, 32'hDEADBEEF, rdy, mwe, maddr, mwd, rv, rd, mwe_rsp);
        vectors++; if (rdy !== 4'b0001) begin errors++; $display("FAIL write_ready: got %b expected 0001", rdy); end
        vectors++; if (mwe !== 1'b1) begin errors++; $display("FAIL write_mem_write: got %b expected 1", mwe); end
        vectors++; if (maddr !== 10'h005) begin errors++; $display("FAIL write_addr: got %h expected 005", maddr); end
        vectors++; if (mwd !== 32'hDEADBEEF) begin errors++; $display("FAIL write_wdata: got %h expected deadbeef", mwd); end
        vectors++; if (rv !== 4'b0001) begin errors++; $display("FAIL write_rsp_valid: got %b expected 0001", rv); end
        vectors++; if (mwe_rsp !== 1'b0) begin errors++; $display("FAIL write_mem_write_resp: got %b expected 0", mwe_rsp); end
        #1;
        vectors++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL write_rsp_pulse_end: got %b expected 0000", rsp_valid); end
    endtask

    task automatic test_read();
        logic [N-1:0] rdy, rv; logic mwe, mwe_rsp; logic [AW-1:0] maddr; logic [DW-1:0] mwd, rd;
        txn(1, 1'b0, 10'h005, 32'h0, rdy, mwe, maddr, mwd, rv, rd, mwe_rsp);
        vectors++; if (rdy !== 4'b0010) begin errors++; $display("FAIL read_ready: got %b expected 0010", rdy); end
        vectors++; if (mwe !== 1'b0) begin errors++; $display("FAIL read_mem_write: got %b expected 0", mwe); end
        vectors++; if (maddr !== 10'h005) begin errors++; $display("FAIL read_addr: got %h expected 005", maddr); end
        vectors++; if (rv !== 4'b0010) begin errors++; $display("FAIL read_rsp_valid: got %b expected 0010", rv); end
        vectors++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef", rd); end
        vectors++; if (mwe_rsp !== 1'b0) begin errors++; $display("FAIL read_mem_write_resp: got %b expected 0", mwe_rsp); end
    endtask

    task automatic test_round_robin();
        int ord [5];
        logic [N-1:0] exp_rdy, exp_rv;
`ifdef MEM_ARB_FIXED_PRIO_EN
        ord = '{0, 0, 0, 0, 0};
`else
        ord = '{0, 1, 2, 3, 0};
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
        for (int c = 0; c < 15; c++) begin
            #1;
            exp_rdy = (c % 3 == 0) ? 4'(1) << ord[c/3] : 4'b0000;
            exp_rv  = (c % 3 == 2) ? 4'(1) << ord[c/3] : 4'b0000;
            vectors++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready cycle %0d: got %b expected %b", c, req_ready, exp_rdy); end
            vectors++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rr_rsp_valid cycle %0d: got %b expected %b", c, rsp_valid, exp_rv); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_sole();
        logic [N-1:0] exp_rdy;
        set_req(2, 1'b1, 1'b0, 10'h005, '0);
        for (int c = 0; c < 15; c++) begin
            #1;
            exp_rdy = (c % 3 == 0) ? 4'b0100 : 4'b0000;
            vectors++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL sole_ready cycle %0d: got %b expected %b", c, req_ready, exp_rdy); end
            if (c % 3 == 2) begin
                vectors++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL sole_rsp_valid cycle %0d: got %b expected 0100", c, rsp_valid); end
                vectors++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sole_rdata cycle %0d: got %h expected deadbeef", c, rsp_rdata); end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        set_req(3, 1'b1, 1'b1, 10'h3FF, 32'hCAFEF00D);
        #1;
        vectors++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_ready: got %b expected 1000", req_ready); end
        @(negedge clk);
        set_req(3, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        #1;
        vectors++; if (mem_write !== 1'b1) begin errors++; $display("FAIL mid_issue_write: got %b expected 1", mem_write); end
        vectors++; if (mem_address !== 10'h3FF) begin errors++; $display("FAIL mid_issue_addr: got %h expected 3ff", mem_address); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_no_rsp: got %b expected 0000", rsp_valid); end
        vectors++; if (mem_write !== 1'b0) begin errors++; $display("FAIL mid_write_cleared: got %b expected 0", mem_write); end
        set_req(0, 1'b1, 1'b0, 10'h3FF, '0);
        #1;
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_idle_ready: got %b expected 0001", req_ready); end
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        vectors++; if (mem_address !== 10'h3FF) begin errors++; $display("FAIL mid_read_addr: got %h expected 3ff", mem_address); end
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL mid_read_rsp: got %b expected 0001", rsp_valid); end
        vectors++; if (rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_read_rdata: got %h expected cafef00d", rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_boundary();
        logic [N-1:0] rdy, rv; logic mwe, mwe_rsp; logic [AW-1:0] maddr; logic [DW-1:0] mwd, rd;
        txn(1, 1'b1, 10'h3FF, 32'h12345678, rdy, mwe, maddr, mwd, rv, rd, mwe_rsp);
        vectors++; if (rdy !== 4'b0010) begin errors++; $display("FAIL bnd_w3ff_ready: got %b expected 0010", rdy); end
        vectors++; if (maddr !== 10'h3FF || mwe !== 1'b1) begin errors++; $display("FAIL bnd_w3ff_issue: got %h/%b expected 3ff/1", maddr, mwe); end
        txn(2, 1'b1, 10'h000, 32'h87654321, rdy, mwe, maddr, mwd, rv, rd, mwe_rsp);
        vectors++; if (rdy !== 4'b0100) begin errors++; $display("FAIL bnd_w000_ready: got %b expected 0100", rdy); end
        vectors++; if (maddr !== 10'h000 || mwd !== 32'h87654321) begin errors++; $display("FAIL bnd_w000_issue: got %h/%h expected 000/87654321", maddr, mwd); end
        txn(3, 1'b0, 10'h3FF, 32'h0, rdy, mwe, maddr, mwd, rv, rd, mwe_rsp);
        vectors++; if (rv !== 4'b1000) begin errors++; $display("FAIL bnd_r3ff_rsp: got %b expected 1000", rv); end
        vectors++; if (rd !== 32'h12345678) begin errors++; $display("FAIL bnd_r3ff_rdata: got %h expected 12345678", rd); end
        txn(0, 1'b0, 10'h000, 32'h0, rdy, mwe, maddr, mwd, rv, rd, mwe_rsp);
        vectors++; if (rv !== 4'b0001) begin errors++; $display("FAIL bnd_r000_rsp: got %b expected 0001", rv); end
        vectors++; if (rd !== 32'h87654321) begin errors++; $display("FAIL bnd_r000_rdata: got %h expected 87654321", rd); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_sole();
        test_reset_mid();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
